mc_load_credit: RTL and testbench

Parametrised memory-controller load port with credit-based flow control and an in-order response buffer. It sits between a circuit load operation and the memory interface channel. It forwards load addresses only while a response slot is guaranteed, so the memory side is never back-pressured for an accepted request. It buffers up to DEPTH returned words, which lets several loads be outstanding at once and gives full throughput on pipelined memories.

---
 rtl/mc_load_credit_if.sv | 38 +++
 rtl/mc_load_credit.sv | 109 ++++++++++
 tb/tb_mc_load_credit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_load_credit_if.sv
// Load-port bundle: circuit address channel, memory address/data channels, result channel and status.
// master = environment side (circuit + memory), slave = the load controller.
interface mc_load_credit_if #(
    parameter int DATA_TYPE = 32,
    parameter int ADDR_TYPE = 32,
    parameter int DEPTH     = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_TYPE-1:0] addrIn;
    logic                 addrIn_valid;
    logic                 addrIn_ready;
    logic [ADDR_TYPE-1:0] addrOut;
    logic                 addrOut_valid;
    logic                 addrOut_ready;
    logic [DATA_TYPE-1:0] dataFromMem;
    logic                 dataFromMem_valid;
    logic                 dataFromMem_ready;
    logic [DATA_TYPE-1:0] dataOut;
    logic                 dataOut_valid;
    logic                 dataOut_ready;
    logic [CNT_W-1:0]     pending;
    logic                 err_unexpected;

    modport master (
        output addrIn, addrIn_valid, addrOut_ready,
        output dataFromMem, dataFromMem_valid, dataOut_ready,
        input  addrIn_ready, addrOut, addrOut_valid, dataFromMem_ready,
        input  dataOut, dataOut_valid, pending, err_unexpected
    );

    modport slave (
        input  addrIn, addrIn_valid, addrOut_ready,
        input  dataFromMem, dataFromMem_valid, dataOut_ready,
        output addrIn_ready, addrOut, addrOut_valid, dataFromMem_ready,
        output dataOut, dataOut_valid, pending, err_unexpected
    );
endinterface

// File: rtl/mc_load_credit.sv
// Credit-gated load port: forwards addresses only while a response slot is reserved,
// and returns memory words in issue order through a DEPTH-entry FIFO.
module mc_load_credit #(
    parameter int DATA_TYPE = 32,
    parameter int ADDR_TYPE = 32,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    mc_load_credit_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0]     pending_q, pending_d;
    logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic                 err_q, err_d;
    logic [DATA_TYPE-1:0] storage_q [DEPTH];

    logic [CNT_W-1:0] inflight;
    logic credit_ok;
    logic dm_ready;
    logic dm_fire;
    logic fifo_wr;
    logic fifo_rd;
    logic unexpected;
    logic dout_valid;
    logic issue;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // Explicit wrap so non-power-of-2 depths work.
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit is taken from registered state only: no path from dataOut_ready to the address side.
    assign credit_ok  = (pending_q < DEPTH_C);
    assign inflight   = pending_q - fifo_count_q;
    assign dm_ready   = (fifo_count_q < DEPTH_C);
    assign dout_valid = (fifo_count_q != '0);

    assign bus.addrOut           = bus.addrIn;
    assign bus.addrOut_valid     = bus.addrIn_valid & credit_ok;
    assign bus.addrIn_ready      = bus.addrOut_ready & credit_ok;
    assign bus.dataFromMem_ready = dm_ready;
    assign bus.dataOut_valid     = dout_valid;
    assign bus.dataOut           = storage_q[rd_ptr_q];
    assign bus.pending           = pending_q;
    assign bus.err_unexpected    = err_q;

    assign issue      = bus.addrIn_valid & credit_ok & bus.addrOut_ready;
    assign dm_fire    = bus.dataFromMem_valid & dm_ready;
    assign fifo_wr    = dm_fire & (inflight != '0);
    assign unexpected = dm_fire & (inflight == '0);
    assign fifo_rd    = dout_valid & bus.dataOut_ready;

    always_comb begin
        pending_d    = pending_q;
        fifo_count_d = fifo_count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        err_d        = err_q | unexpected;

        case ({issue, fifo_rd})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase

        case ({fifo_wr, fifo_rd})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        if (fifo_wr) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (fifo_rd) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q    <= '0;
            fifo_count_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            fifo_count_q <= fifo_count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            err_q        <= err_d;
        end
    end

    // Storage has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            storage_q[wr_ptr_q] <= bus.dataFromMem;
        end
    end
endmodule

// File: tb/tb_mc_load_credit.sv
// Directed + randomized bench for mc_load_credit (DEPTH=4 and DEPTH=3 instances) against a
// count/queue reference model and an in-order fixed-latency memory model.
module tb_mc_load_credit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    mc_load_credit_if #(.DATA_TYPE(32), .ADDR_TYPE(32), .DEPTH(4)) if4 ();
    mc_load_credit_if #(.DATA_TYPE(32), .ADDR_TYPE(32), .DEPTH(3)) if3 ();

    mc_load_credit #(.DATA_TYPE(32), .ADDR_TYPE(32), .DEPTH(4)) dut4 (.clk(clk), .rst(rst_n), .bus(if4));
    mc_load_credit #(.DATA_TYPE(32), .ADDR_TYPE(32), .DEPTH(3)) dut3 (.clk(clk), .rst(rst_n), .bus(if3));

    // index 0 -> DEPTH=4 instance, index 1 -> DEPTH=3 instance
    logic [31:0] a_addr [2];
    logic        a_val  [2];
    logic        ao_rdy [2];
    logic [31:0] dm_data[2];
    logic        dm_val [2];
    logic        do_rdy [2];

    logic        o_ain_rdy [2];
    logic [31:0] o_aout    [2];
    logic        o_aout_val[2];
    logic        o_dm_rdy  [2];
    logic [31:0] o_dout    [2];
    logic        o_dout_val[2];
    logic [31:0] o_pend    [2];
    logic        o_err     [2];

    assign if4.addrIn = a_addr[0];  assign if4.addrIn_valid = a_val[0];
    assign if4.addrOut_ready = ao_rdy[0];
    assign if4.dataFromMem = dm_data[0];  assign if4.dataFromMem_valid = dm_val[0];
    assign if4.dataOut_ready = do_rdy[0];
    assign o_ain_rdy[0] = if4.addrIn_ready;  assign o_aout[0] = if4.addrOut;
    assign o_aout_val[0] = if4.addrOut_valid;  assign o_dm_rdy[0] = if4.dataFromMem_ready;
    assign o_dout[0] = if4.dataOut;  assign o_dout_val[0] = if4.dataOut_valid;
    assign o_pend[0] = 32'(if4.pending);  assign o_err[0] = if4.err_unexpected;

    assign if3.addrIn = a_addr[1];  assign if3.addrIn_valid = a_val[1];
    assign if3.addrOut_ready = ao_rdy[1];
    assign if3.dataFromMem = dm_data[1];  assign if3.dataFromMem_valid = dm_val[1];
    assign if3.dataOut_ready = do_rdy[1];
    assign o_ain_rdy[1] = if3.addrIn_ready;  assign o_aout[1] = if3.addrOut;
    assign o_aout_val[1] = if3.addrOut_valid;  assign o_dm_rdy[1] = if3.dataFromMem_ready;
    assign o_dout[1] = if3.dataOut;  assign o_dout_val[1] = if3.dataOut_valid;
    assign o_pend[1] = 32'(if3.pending);  assign o_err[1] = if3.err_unexpected;

    // Reference model: loads outstanding, words held, expected results in issue order.
    logic [31:0] exp_q[$];
    logic [31:0] mem_data_q[$];
    int          mem_due_q[$];
    int          cyc;
    int          m_pending;
    int          m_fifo;
    bit          m_err;
    int          out_cnt;
    int          vectors;
    int          miscompares;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        assert (act === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        mem_data_q.delete();
        mem_due_q.delete();
        m_pending = 0;
        m_fifo    = 0;
        m_err     = 1'b0;
    endtask

    // One clock cycle on instance d: drive at negedge, check just after, update model at posedge.
    task automatic step(input int d, input bit av, input logic [31:0] addr, input bit dordy,
                        input int lat, input bit inject, output bit issued);
        int          depth;
        bit          dv, iss, rd, wr, unexp;
        logic [31:0] dd;
        depth = (d == 0) ? 4 : 3;
        @(negedge clk);
        a_val[d]  = av;
        a_addr[d] = addr;
        ao_rdy[d] = 1'b1;
        do_rdy[d] = dordy;
        dv = 1'b0;
        dd = '0;
        if (inject) begin
            dv = 1'b1;
            dd = 32'hDEAD;
        end else if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            dv = 1'b1;
            dd = mem_data_q[0];
        end
        dm_val[d]  = dv;
        dm_data[d] = dd;
        #1;
        iss   = av && (m_pending < depth);
        rd    = (m_fifo > 0) && dordy;
        wr    = dv && (m_fifo < depth) && (m_pending - m_fifo > 0);
        unexp = dv && (m_fifo < depth) && (m_pending - m_fifo == 0);
        chk("pending", o_pend[d], 32'(m_pending));
        chk("addrIn_ready", 32'(o_ain_rdy[d]), 32'(m_pending < depth));
        chk("addrOut_valid", 32'(o_aout_val[d]), 32'(iss));
        if (av) chk("addrOut", o_aout[d], addr);
        chk("dataOut_valid", 32'(o_dout_val[d]), 32'(m_fifo > 0));
        if (m_fifo > 0) chk("dataOut", o_dout[d], exp_q[0]);
        chk("dataFromMem_ready", 32'(o_dm_rdy[d]), 32'(m_fifo < depth));
        chk("err_unexpected", 32'(o_err[d]), 32'(m_err));
        @(posedge clk);
        if (iss) begin
            exp_q.push_back(addr + 32'h100);
            mem_data_q.push_back(addr + 32'h100);
            mem_due_q.push_back(cyc + lat);
        end
        if (wr) begin
            void'(mem_data_q.pop_front());
            void'(mem_due_q.pop_front());
            m_fifo++;
        end
        if (unexp) m_err = 1'b1;
        if (rd) begin
            void'(exp_q.pop_front());
            m_fifo--;
            out_cnt++;
        end
        m_pending = m_pending + int'(iss) - int'(rd);
        cyc++;
        issued = iss;
    endtask

    // Asynchronous reset mid-cycle; checks values while held, then synchronous release.
    task automatic do_reset(input int d);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        clear_model();
        for (int k = 0; k < 2; k++) begin
            a_val[k]  = 1'b0;
            dm_val[k] = 1'b0;
            do_rdy[k] = 1'b0;
        end
        chk("rst_pending", o_pend[d], 32'd0);
        chk("rst_dataOut_valid", 32'(o_dout_val[d]), 32'd0);
        chk("rst_dataFromMem_ready", 32'(o_dm_rdy[d]), 32'd1);
        chk("rst_err", 32'(o_err[d]), 32'd0);
        a_val[d] = 1'b1;
        #1 chk("rst_addrOut_valid_hi", 32'(o_aout_val[d]), 32'd1);
        a_val[d] = 1'b0;
        #1 chk("rst_addrOut_valid_lo", 32'(o_aout_val[d]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          iss;
        int          n;
        int          c;
        int          maxp;
        logic [31:0] addr;

        vectors = 0; miscompares = 0; cyc = 0; out_cnt = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_addr[k] = '0; a_val[k] = 1'b0; ao_rdy[k] = 1'b1;
            dm_data[k] = '0; dm_val[k] = 1'b0; do_rdy[k] = 1'b0;
        end
        clear_model();
        do_reset(0);
        do_reset(1);

        // Pipelined memory, 2-cycle latency, 16 loads at full rate.
        n = 0; addr = 32'h0; out_cnt = 0;
        for (c = 0; c < 40 && n < 16; c++) begin
            step(0, 1'b1, addr, 1'b1, 2, 1'b0, iss);
            if (iss) begin n++; addr += 32'h4; end
        end
        chk("pipe_issued", 32'(n), 32'd16);
        chk("pipe_issue_cycles", 32'(c), 32'd16);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(0, 1'b0, '0, 1'b1, 2, 1'b0, iss);
        chk("pipe_results", 32'(out_cnt), 32'd16);
        $display("pipelined: %0d loads issued in %0d cycles, %0d results", n, c, out_cnt);

        // Credit stall: 6 offered with dataOut_ready low.
        n = 0; addr = 32'h200;
        for (int k = 0; k < 8; k++) begin
            step(0, (n < 6), addr, 1'b0, 2, 1'b0, iss);
            if (iss) begin n++; addr += 32'h4; end
        end
        chk("stall_issued", 32'(n), 32'd4);
        #1 chk("stall_pending", o_pend[0], 32'd4);
        step(0, 1'b1, addr, 1'b1, 2, 1'b0, iss);
        chk("stall_blocked", 32'(iss), 32'd0);
        step(0, 1'b1, addr, 1'b0, 2, 1'b0, iss);
        chk("stall_fifth_issue", 32'(iss), 32'd1);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(0, 1'b0, '0, 1'b1, 2, 1'b0, iss);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);
        $display("credit stall: 4 issued before stall, 5th issued after one consume");

        // Simultaneous issue and consume at pending=3.
        for (int k = 0; k < 3; k++) step(0, 1'b1, 32'h300 + 32'(k * 4), 1'b0, 2, 1'b0, iss);
        for (int k = 0; k < 4; k++) step(0, 1'b0, '0, 1'b0, 2, 1'b0, iss);
        step(0, 1'b1, 32'h30C, 1'b1, 2, 1'b0, iss);
        #1 chk("simul_pending", o_pend[0], 32'd3);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(0, 1'b0, '0, 1'b1, 2, 1'b0, iss);
        chk("simul_drained", 32'(exp_q.size()), 32'd0);
        $display("simultaneous issue/consume at pending=3 done");

        // Unexpected response with nothing in flight.
        step(0, 1'b0, '0, 1'b1, 2, 1'b1, iss);
        for (int k = 0; k < 3; k++) step(0, 1'b0, '0, 1'b1, 2, 1'b0, iss);
        #1 chk("unexp_err_sticky", 32'(o_err[0]), 32'd1);
        chk("unexp_dropped", 32'(o_dout_val[0]), 32'd0);
        do_reset(0);
        $display("unexpected response: err set, word dropped, cleared by reset");

        // Reset mid-stream with pending=3.
        for (int k = 0; k < 3; k++) step(0, 1'b1, 32'h400 + 32'(k * 4), 1'b0, 2, 1'b0, iss);
        #1 chk("midrst_pending_before", o_pend[0], 32'd3);
        do_reset(0);
        $display("mid-stream reset with pending=3 done");

        // DEPTH=3: 10 random loads under random dataOut_ready, pointer wrap.
        do_reset(1);
        n = 0; out_cnt = 0; maxp = 0;
        addr = $urandom() & 32'h0FFF_FFFC;
        for (int k = 0; k < 300 && (n < 10 || exp_q.size() > 0); k++) begin
            step(1, (n < 10), addr, 1'($urandom_range(0, 1)), 2, 1'b0, iss);
            if (iss) begin n++; addr = $urandom() & 32'h0FFF_FFFC; end
            if (int'(o_pend[1]) > maxp) maxp = int'(o_pend[1]);
        end
        chk("wrap_issued", 32'(n), 32'd10);
        chk("wrap_results", 32'(out_cnt), 32'd10);
        chk("wrap_max_pending_le3", 32'(maxp <= 3), 32'd1);
        $display("depth3 wrap: %0d issued, %0d results, max pending %0d", n, out_cnt, maxp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
